sr_cmd_gen: RTL and testbench

Upstream command stage for the SR flip-flop: turns two raw, asynchronous set/clear request lines (buttons, external strobes) into clean, single-cycle `s`/`r` pulses that drive the flop's `s`/`r` inputs directly. Each input is synchronised and debounced, and only its rising edge produces a pulse. Simultaneous requests are arbitrated, so the illegal `s=r=1` combination is never presented downstream.

---
 rtl/sr_cmd_gen.sv | 101 ++++++++++
 tb/tb_sr_cmd_gen.sv | 130 +++++++++++++
 2 files changed

// File: rtl/sr_cmd_gen.sv
// Set/clear command generator: sync + debounce two raw request lines, emit
// arbitrated single-cycle s/r pulses on debounced rising edges.

module sr_cmd_gen_chan #(
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic clk,
  input  logic res,
  input  logic raw_i,
  output logic rise_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT - 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_MAX) db_d  = sync2_q;
      else                  cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Rise is taken from the next-state value so the pulse lands on the same edge db flips.
  assign rise_o = db_d & ~db_q;

  always_ff @(posedge clk) begin
    if (!res) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

module sr_cmd_gen #(
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned CLR_PRIORITY = 1
) (
  input  logic clk,
  input  logic res,
  input  logic set_in,
  input  logic clr_in,
  output logic s,
  output logic r,
  output logic conflict
);
  localparam int unsigned NUM_CH = 2;  // lane 0 = set, lane 1 = clear
  localparam bit CLR_WINS = (CLR_PRIORITY != 0);

  logic [NUM_CH-1:0] raw, req;
  logic s_q, s_d, r_q, r_d, conflict_q, conflict_d;

  assign raw = {clr_in, set_in};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sr_cmd_gen_chan #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk   (clk),
      .res   (res),
      .raw_i (raw[g]),
      .rise_o(req[g])
    );
  end

  // Loser of a collision is dropped outright, never queued.
  always_comb begin
    conflict_d = req[0] & req[1];
    s_d        = req[0] & (~req[1] | ~CLR_WINS);
    r_d        = req[1] & (~req[0] |  CLR_WINS);
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign conflict = conflict_q;
endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench for sr_cmd_gen: two instances, clear-priority and set-priority.

module tb_sr_cmd_gen;
  logic clk = 1'b0;
  logic res, set_in, clr_in;
  logic s0, r0, c0, s1, r1, c1;
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  sr_cmd_gen #(.DEBOUNCE_CNT(4), .CNT_W(4), .CLR_PRIORITY(1)) u0 (
    .clk(clk), .res(res), .set_in(set_in), .clr_in(clr_in),
    .s(s0), .r(r0), .conflict(c0)
  );

  sr_cmd_gen #(.DEBOUNCE_CNT(4), .CNT_W(4), .CLR_PRIORITY(0)) u1 (
    .clk(clk), .res(res), .set_in(set_in), .clr_in(clr_in),
    .s(s1), .r(r1), .conflict(c1)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // s and r must never be high together on either instance.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("inv_u0_s_and_r", s0 & r0, 1'b0);
      chk("inv_u1_s_and_r", s1 & r1, 1'b0);
    end
  end

  // Runs n edges (index k = edge k from now); compares outputs after each.
  // Pulse positions of -1 mean "never high".
  task automatic win(input string tag, input int n,
                     input int s_at, input int r_at, input int c_at,
                     input int s1_at, input int r1_at);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      chk({tag, "_u0_s"}, s0, k == s_at);
      chk({tag, "_u0_r"}, r0, k == r_at);
      chk({tag, "_u0_c"}, c0, k == c_at);
      chk({tag, "_u1_s"}, s1, k == s1_at);
      chk({tag, "_u1_r"}, r1, k == r1_at);
      chk({tag, "_u1_c"}, c1, k == c_at);
    end
  endtask

  task automatic do_reset();
    set_in = 1'b0; clr_in = 1'b0; res = 1'b0;
    win("rst", 2, -1, -1, -1, -1, -1);
    res = 1'b1;
  endtask

  initial begin
    res = 1'b0; set_in = 1'b1; clr_in = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // 1: reset held with set_in high, then one pulse at edge 5 after release
    win("t1_rst", 3, -1, -1, -1, -1, -1);
    res = 1'b1;
    win("t1_rel", 12, 5, -1, -1, 5, -1);
    set_in = 1'b0;
    win("t1_fall", 10, -1, -1, -1, -1, -1);

    // 2: clean set held 20 cycles, release gives no pulse
    do_reset();
    set_in = 1'b1;
    win("t2_set", 20, 5, -1, -1, 5, -1);
    set_in = 1'b0;
    win("t2_fall", 10, -1, -1, -1, -1, -1);

    // 3: 2-cycle glitch rejected; a following real rise still takes full latency
    do_reset();
    set_in = 1'b1;
    win("t3_gl_hi", 2, -1, -1, -1, -1, -1);
    set_in = 1'b0;
    win("t3_gl_lo", 13, -1, -1, -1, -1, -1);
    set_in = 1'b1;
    win("t3_real", 8, 5, -1, -1, 5, -1);
    set_in = 1'b0;
    win("t3_fall", 8, -1, -1, -1, -1, -1);

    // 4: simultaneous rise; u0 clear wins, u1 set wins, both flag conflict
    do_reset();
    set_in = 1'b1; clr_in = 1'b1;
    win("t4_coll", 10, -1, 5, 5, 5, -1);
    set_in = 1'b0; clr_in = 1'b0;
    win("t4_fall", 8, -1, -1, -1, -1, -1);

    // 5: set pulse, set low 10 cycles, then clear pulse 5 edges later
    do_reset();
    set_in = 1'b1;
    win("t5_set", 8, 5, -1, -1, 5, -1);
    set_in = 1'b0;
    win("t5_gap", 10, -1, -1, -1, -1, -1);
    clr_in = 1'b1;
    win("t5_clr", 8, -1, 5, -1, -1, 5);
    clr_in = 1'b0;
    win("t5_fall", 8, -1, -1, -1, -1, -1);

    // 6: reset at edge 3 mid-debounce discards progress; pulse 5 edges after release
    do_reset();
    set_in = 1'b1;
    win("t6_pre", 3, -1, -1, -1, -1, -1);
    res = 1'b0;
    win("t6_rst", 1, -1, -1, -1, -1, -1);
    res = 1'b1;
    win("t6_rel", 10, 5, -1, -1, 5, -1);
    set_in = 1'b0;
    win("t6_fall", 8, -1, -1, -1, -1, -1);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
